// File: rtl/mux_arb_pkg.sv
// Shared types and sizes for the mux_arbiter slice.
package mux_arb_pkg;

  localparam int unsigned N_REQ         = 4;
  localparam int unsigned SEL_W         = 2;
  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/mux_arbiter_rr_pick.sv
// Combinational winner picker: round-robin from ptr, or fixed priority
// (index 0 highest) when MUX_ARBITER_FIXED_PRIO_EN is defined.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic             found;
  logic [SEL_W-1:0] cand;

`ifdef MUX_ARBITER_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Lowest set bit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = SEL_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end
`else
  // Scan ptr, ptr+1, ... modulo N_REQ; the first requester found wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ptr + SEL_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end
`endif

  assign any   = |req;
  assign grant = any ? (N_REQ'(1) << idx) : '0;

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter in front of a registered 4:1 data mux with a
// valid/ready output. MUX_ARBITER_FIXED_PRIO_EN selects fixed priority.
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_REQ-1:0] i_req,
  input  logic [WIDTH-1:0] i_data_0,
  input  logic [WIDTH-1:0] i_data_1,
  input  logic [WIDTH-1:0] i_data_2,
  input  logic [WIDTH-1:0] i_data_3,
  output logic [N_REQ-1:0] o_grant,
  output logic [SEL_W-1:0] o_ctrl,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] ctrl_q, ctrl_d;
  logic [SEL_W-1:0] ptr_q;

  logic [N_REQ-1:0] pick_grant;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;
  logic             load;
  logic [WIDTH-1:0] sel_data;

  rr_pick u_pick (
    .req   (i_req),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // A load is possible when the output slot is empty or being taken now.
  assign load    = pick_any && (!o_valid || i_ready) && !i_rst;
  assign o_grant = load ? pick_grant : '0;
  assign o_valid = (state_q == HOLD);

  always_comb begin
    sel_data = i_data_0;
    unique case (pick_idx)
      2'd0: sel_data = i_data_0;
      2'd1: sel_data = i_data_1;
      2'd2: sel_data = i_data_2;
      2'd3: sel_data = i_data_3;
      default: sel_data = i_data_0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

`ifdef MUX_ARBITER_FIXED_PRIO_EN
  assign ptr_q = '0;
`else
  // Next search starts just after the last winner.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q <= '0;
    end else if (load) begin
      ptr_q <= pick_idx + SEL_W'(1);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (load) begin
      data_d = sel_data;
      ctrl_d = pick_idx;
    end
    unique case (state_q)
      IDLE: if (load) state_d = HOLD;
      HOLD: begin
        if (load)         state_d = HOLD;
        else if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_data = data_q;
  assign o_ctrl = ctrl_q;

endmodule
